// File: rtl/counter_sched.sv
// Three-requester round-robin scheduler for one shared up-counter.
// A granted job counts 0..L, pulses DONE for one cycle, and may be aborted by dropping its request.
module counter_sched #(
  parameter int W = 3
) (
  input  logic           CLK,
  input  logic           RES,
  input  logic [2:0]     REQ,
  input  logic [3*W-1:0] LEN,
  output logic [2:0]     GNT,
  output logic [W-1:0]   CNT,
  output logic [2:0]     DONE,
  output logic           BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [1:0]     win_r, win_s, pick_s;
  logic [1:0]     ptr_r, ptr_s;
  logic [W-1:0]   len_r, len_s;
  logic [W-1:0]   cnt_r, cnt_s;
  logic [2:0]     gnt_r, gnt_s;
  logic [2:0]     done_r, done_s;
  logic           busy_r, busy_s;

  // Round-robin: search starts just after the last served requester and wraps.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] a, b, c;
    case (ptr)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (req[a])      rr_pick = a;
    else if (req[b]) rr_pick = b;
    else             rr_pick = c;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_s = state_r;
    win_s   = win_r;
    ptr_s   = ptr_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    pick_s  = rr_pick(REQ, ptr_r);
    case (state_r)
      IDLE: begin
        if (|REQ) begin
          win_s   = pick_s;
          len_s   = LEN[pick_s*W +: W];
          cnt_s   = {W{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Abort has priority over completion, even on the terminal count.
        if (!REQ[win_r]) begin
          state_s = IDLE;
          ptr_s   = win_r;
        end else if (cnt_r == len_r) begin
          state_s = FIN;
        end else begin
          cnt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
        end
      end
      FIN: begin
        state_s = IDLE;
        ptr_s   = win_r;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (state_s != IDLE) begin
      gnt_s  = onehot3(win_s);
      busy_s = 1'b1;
    end else begin
      gnt_s  = 3'b000;
      busy_s = 1'b0;
    end
    if (state_s == FIN) begin
      done_s = onehot3(win_s);
    end else begin
      done_s = 3'b000;
    end
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_r <= IDLE;
      win_r   <= 2'd0;
      ptr_r   <= 2'd2;
      len_r   <= {W{1'b0}};
      cnt_r   <= {W{1'b0}};
      gnt_r   <= 3'b000;
      done_r  <= 3'b000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      win_r   <= win_s;
      ptr_r   <= ptr_s;
      len_r   <= len_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign GNT  = gnt_r;
  assign CNT  = cnt_r;
  assign DONE = done_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_counter_sched.sv
// Randomized bench for counter_sched against a job-level reference model.
module tb_counter_sched;
  localparam int W = 3;

  logic           CLK;
  logic           RES;
  logic [2:0]     REQ;
  logic [3*W-1:0] LEN;
  logic [2:0]     GNT;
  logic [W-1:0]   CNT;
  logic [2:0]     DONE;
  logic           BUSY;

  int tests_run;
  int tests_failed;

  // Reference model: a job is "active" for L+2 cycles; n counts cycles since the grant.
  bit m_active;
  int m_win, m_len, m_n, m_ptr, m_cnt;

  counter_sched #(.W(W)) dut (
    .CLK(CLK), .RES(RES), .REQ(REQ), .LEN(LEN),
    .GNT(GNT), .CNT(CNT), .DONE(DONE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr    = 2;
    m_cnt    = 0;
    m_n      = 0;
    m_win    = 0;
    m_len    = 0;
  endtask

  task automatic model_edge(input logic [2:0] req, input logic [3*W-1:0] len);
    if (!m_active) begin
      if (req != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (req[(m_ptr + k) % 3]) begin
            m_win = (m_ptr + k) % 3;
            break;
          end
        end
        m_len    = int'((len >> (m_win * W)) & ((1 << W) - 1));
        m_active = 1'b1;
        m_n      = 0;
        m_cnt    = 0;
      end
    end else if (m_n <= m_len) begin
      if (!req[m_win]) begin
        m_active = 1'b0;
        m_ptr    = m_win;
      end else begin
        m_n++;
        m_cnt = (m_n <= m_len) ? m_n : m_len;
      end
    end else begin
      m_active = 1'b0;
      m_ptr    = m_win;
    end
  endtask

  task automatic compare_all(input string where);
    logic [2:0] exp_gnt, exp_done;
    exp_gnt  = m_active ? 3'(1 << m_win) : 3'b000;
    exp_done = (m_active && m_n == m_len + 1) ? 3'(1 << m_win) : 3'b000;
    chk({where, "_gnt"},  32'(GNT),  32'(exp_gnt));
    chk({where, "_done"}, 32'(DONE), 32'(exp_done));
    chk({where, "_cnt"},  32'(CNT),  32'(m_cnt));
    chk({where, "_busy"}, 32'(BUSY), 32'(m_active));
  endtask

  // Inputs are applied 1 time unit after a rising edge and outputs checked at the same point.
  task automatic step(input logic [2:0] req, input logic [3*W-1:0] len, input string where);
    REQ = req;
    LEN = len;
    @(posedge CLK);
    model_edge(req, len);
    #1;
    compare_all(where);
  endtask

  task automatic pulse_reset(input string where);
    #2;
    RES = 1'b0;
    #1;
    model_reset();
    compare_all({where, "_async"});
    @(posedge CLK);
    #1;
    compare_all({where, "_held"});
    RES = 1'b1;
  endtask

  function automatic logic [3*W-1:0] lens(input int l2, input int l1, input int l0);
    lens = {3'(l2), 3'(l1), 3'(l0)};
  endfunction

  initial begin
    logic [2:0] rq;
    tests_run    = 0;
    tests_failed = 0;
    REQ = 3'b000;
    LEN = '0;
    RES = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    #10;
    RES = 1'b1;
    @(posedge CLK);
    #1;

    // Single job, L0=3: five granted cycles, then idle.
    for (int i = 0; i < 5; i++) step(3'b001, lens(6, 6, 3), "single");
    for (int i = 0; i < 3; i++) step(3'b000, lens(6, 6, 3), "single_idle");

    // Contention with all lengths 2: grant order 0,1,2,0.
    for (int i = 0; i < 16; i++) step(3'b111, lens(2, 2, 2), "contend");
    for (int i = 0; i < 4; i++) step(3'b000, lens(2, 2, 2), "contend_idle");

    // Zero length on requester 1.
    for (int i = 0; i < 2; i++) step(3'b010, lens(5, 0, 5), "zero");
    for (int i = 0; i < 2; i++) step(3'b000, lens(5, 0, 5), "zero_idle");

    // Maximum length on requester 2: nine busy cycles, no wrap.
    for (int i = 0; i < 9; i++) step(3'b100, lens(7, 1, 1), "maxlen");
    for (int i = 0; i < 2; i++) step(3'b000, lens(7, 1, 1), "maxlen_idle");

    // Abort requester 0 at CNT=1 while requester 1 waits.
    for (int i = 0; i < 2; i++) step(3'b011, lens(0, 1, 5), "abort_run");
    for (int i = 0; i < 5; i++) step(3'b010, lens(0, 1, 5), "abort_next");
    for (int i = 0; i < 3; i++) step(3'b000, lens(0, 1, 5), "abort_idle");

    // Mid-run reset at CNT=2, then REQ=110 must go to requester 1.
    for (int i = 0; i < 3; i++) step(3'b001, lens(4, 4, 5), "midrst_run");
    pulse_reset("midrst");
    for (int i = 0; i < 3; i++) step(3'b110, lens(1, 1, 1), "midrst_after");

    // Randomized traffic: requests mostly held, lengths changing freely, rare resets.
    rq = 3'($urandom_range(0, 7));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset("rand_rst");
      end else begin
        step(rq, (3*W)'($urandom), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
